// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: register-address width,
// the hard-wired zero register and the writeback entry layout.
package wb_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // Nominal data width of a writeback entry; the arbiter and FIFO
  // themselves are parameterised separately through DATA_W.
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Mul/div writeback FIFO. Stores {valid, rd, data}; an entry can be killed
// in place (valid cleared) by a newer ALU write to the same rd, but still
// occupies its slot until popped. Also answers "is a live write to rs/rt
// still pending" for the decode stage.
module wb_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  kill,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  output logic                  full,
  output logic                  empty,
  output logic                  head_valid,
  output logic [REG_ADDR_W-1:0] head_rd,
  output logic [DATA_W-1:0]     head_data,
  output logic                  pend_rs,
  output logic                  pend_rt,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [DEPTH-1:0]      valid_q;
  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           occ;

  assign full       = (occ == FULL_OCC);
  assign empty      = (occ == '0);
  assign occupancy  = occ;
  assign head_valid = valid_q[rd_ptr];
  assign head_rd    = rd_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];

  // Storage, pointers and occupancy. Valid bits are cleared on pop so a set
  // valid bit always means "stored and live". A push in the same cycle as a
  // kill is assigned last, so the newer entry stays live.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
    end else begin
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_q[i] == kill_rd) valid_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        rd_q[wr_ptr]    <= push_rd;
        data_q[wr_ptr]  <= push_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Pending-write lookup against decode source registers.
  always_comb begin
    pend_rs = 1'b0;
    pend_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && rd_q[i] == rs && rs != ZERO_REG) pend_rs = 1'b1;
      if (valid_q[i] && rd_q[i] == rt && rt != ZERO_REG) pend_rt = 1'b1;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write arbiter. Merges the single-cycle ALU/load result
// (always accepted, highest priority) with buffered mul/div results into one
// registered register-file write per cycle, and reports pending/forwardable
// writes to decode. Optional forwarding is built when WB_FWD_EN is defined.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0]     rf_data,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  output logic                  pend_rs,
  output logic                  pend_rt,
  output logic                  fwd_rs_hit,
  output logic                  fwd_rt_hit,
  output logic [DATA_W-1:0]     fwd_rs_data,
  output logic [DATA_W-1:0]     fwd_rt_data,
  output logic [$clog2(DEPTH):0] occupancy
);

  logic                  full;
  logic                  empty;
  logic                  head_valid;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0]     head_data;
  logic                  alu_hit;
  logic                  md_push;
  logic                  fifo_pop;

  // mul/div handshake: a result transfers on a cycle where md_valid and
  // md_ready are both high. md_ready depends only on registered occupancy,
  // never on md_valid. A transferred result with md_rd==0 is dropped.
  assign md_ready = !full;
  assign md_push  = md_valid && md_ready && (md_rd != ZERO_REG);

  // ALU writes to x0 are no-ops and must not block draining.
  assign alu_hit  = alu_valid && (alu_rd != ZERO_REG);
  assign fifo_pop = !alu_hit && !empty;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (md_push),
    .push_rd    (md_rd),
    .push_data  (md_data),
    .pop        (fifo_pop),
    .kill       (alu_hit),
    .kill_rd    (alu_rd),
    .rs         (rs),
    .rt         (rt),
    .full       (full),
    .empty      (empty),
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .pend_rs    (pend_rs),
    .pend_rt    (pend_rt),
    .occupancy  (occupancy)
  );

  // Registered write port: ALU first, else FIFO head (killed heads pop silently).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_rd   <= ZERO_REG;
      rf_data <= '0;
    end else if (alu_hit) begin
      rf_we   <= 1'b1;
      rf_rd   <= alu_rd;
      rf_data <= alu_data;
    end else if (fifo_pop && head_valid) begin
      rf_we   <= 1'b1;
      rf_rd   <= head_rd;
      rf_data <= head_data;
    end else begin
      rf_we   <= 1'b0;
      rf_rd   <= ZERO_REG;
      rf_data <= '0;
    end
  end

`ifdef WB_FWD_EN
  // Forward the write in flight, covering the cycle before the register file updates.
  assign fwd_rs_hit  = rf_we && (rf_rd == rs) && (rs != ZERO_REG);
  assign fwd_rt_hit  = rf_we && (rf_rd == rt) && (rt != ZERO_REG);
  assign fwd_rs_data = fwd_rs_hit ? rf_data : '0;
  assign fwd_rt_data = fwd_rt_hit ? rf_data : '0;
`else
  assign fwd_rs_hit  = 1'b0;
  assign fwd_rt_hit  = 1'b0;
  assign fwd_rs_data = '0;
  assign fwd_rt_data = '0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected register-file writes are
// queued in exp_q and matched by a negedge monitor; point checks use
// immediate assertions.
module tb_wb_write_arbiter;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int W      = 5 + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              md_valid;
  logic              md_ready;
  logic [4:0]        md_rd;
  logic [DATA_W-1:0] md_data;
  logic              rf_we;
  logic [4:0]        rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic              pend_rs;
  logic              pend_rt;
  logic              fwd_rs_hit;
  logic              fwd_rt_hit;
  logic [DATA_W-1:0] fwd_rs_data;
  logic [DATA_W-1:0] fwd_rt_data;
  logic [$clog2(DEPTH):0] occupancy;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  wb_write_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .md_valid    (md_valid),
    .md_ready    (md_ready),
    .md_rd       (md_rd),
    .md_data     (md_data),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_data     (rf_data),
    .rs          (rs),
    .rt          (rt),
    .pend_rs     (pend_rs),
    .pend_rt     (pend_rt),
    .fwd_rs_hit  (fwd_rs_hit),
    .fwd_rt_hit  (fwd_rt_hit),
    .fwd_rs_data (fwd_rs_data),
    .fwd_rt_data (fwd_rt_data),
    .occupancy   (occupancy)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [DATA_W-1:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
    if (v && rd != 5'd0) exp_q.push_back({rd, d});
  endtask

  task automatic drive_md(input logic v, input logic [4:0] rd, input logic [DATA_W-1:0] d);
    md_valid = v;
    md_rd    = rd;
    md_data  = d;
  endtask

  // Scoreboard: every rf write must match the oldest expected write
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, rf_rd, rf_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("rf_write", {27'd0, rf_rd, rf_data}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rs = 5'd0;
    rt = 5'd0;
    drive_alu(1'b0, 5'd0, '0);
    drive_md(1'b0, 5'd0, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset / idle
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_rd", rf_rd, 0);
    check("rst_rf_data", rf_data, 0);
    check("rst_md_ready", md_ready, 1);
    check("rst_occ", occupancy, 0);

    // Single md push, drained the next cycle
    drive_md(1'b1, 5'd3, 32'h11);
    exp_q.push_back({5'd3, 32'h11});
    tick();
    drive_md(1'b0, 5'd0, '0);
    rs = 5'd3;
    #1;
    check("single_occ1", occupancy, 1);
    check("single_pend_rs", pend_rs, 1);
    tick();
    check("single_rf_we", rf_we, 1);
    check("single_rf_rd", rf_rd, 3);
    check("single_rf_data", rf_data, 32'h11);
    check("single_occ0", occupancy, 0);
    rs = 5'd0;

    // Fill under continuous ALU traffic
    for (int k = 1; k <= 4; k++) begin
      drive_alu(1'b1, 5'd9, 32'h900 + k);
      drive_md(1'b1, 5'(k), 32'hD0 + k);
      tick();
    end
    check("fill_occ", occupancy, 4);
    check("fill_md_ready", md_ready, 0);
    check("fill_rf_rd_alu", rf_rd, 9);
    rt = 5'd2;
    #1;
    check("fill_pend_rt", pend_rt, 1);
    rt = 5'd0;
    // Offer rd=5 while full: must not be taken
    drive_alu(1'b1, 5'd9, 32'h905);
    drive_md(1'b1, 5'd5, 32'hEE);
    tick();
    check("full_hold_occ", occupancy, 4);
    // Drain with an x0 ALU write that must not block the FIFO
    drive_md(1'b0, 5'd0, '0);
    drive_alu(1'b1, 5'd0, 32'hDEAD);
    for (int k = 1; k <= 4; k++) exp_q.push_back({5'(k), 32'hD0 + k});
    tick();
    check("drain_rf_rd1", rf_rd, 1);
    tick();
    tick();
    tick();
    check("drain_rf_rd4", rf_rd, 4);
    check("drain_occ", occupancy, 0);
    drive_alu(1'b0, 5'd0, '0);
    tick();
    check("drain_idle_we", rf_we, 0);

    // WAW kill
    drive_alu(1'b1, 5'd9, 32'h9A);
    drive_md(1'b1, 5'd5, 32'hAA);
    tick();
    drive_md(1'b0, 5'd0, '0);
    rs = 5'd5;
    #1;
    check("kill_pend_before", pend_rs, 1);
    drive_alu(1'b1, 5'd5, 32'hBB);
    tick();
    check("kill_rf_data", rf_data, 32'hBB);
    check("kill_pend_after", pend_rs, 0);
    check("kill_occ_kept", occupancy, 1);
    drive_alu(1'b0, 5'd0, '0);
    tick();
    check("kill_pop_we", rf_we, 0);
    check("kill_pop_occ", occupancy, 0);

    // Same-cycle newer push survives the kill
    drive_alu(1'b1, 5'd6, 32'h66);
    drive_md(1'b1, 5'd6, 32'h77);
    tick();
    rs = 5'd6;
    drive_md(1'b0, 5'd0, '0);
    drive_alu(1'b0, 5'd0, '0);
    exp_q.push_back({5'd6, 32'h77});
    #1;
    check("newer_pend", pend_rs, 1);
    tick();
    check("newer_rf_data", rf_data, 32'h77);
    check("newer_occ", occupancy, 0);
    rs = 5'd0;

    // Accepted md with rd=0 is discarded
    drive_md(1'b1, 5'd0, 32'h55);
    tick();
    drive_md(1'b0, 5'd0, '0);
    check("x0_occ", occupancy, 0);
    tick();
    check("x0_rf_we", rf_we, 0);

    // Forwarding of the write in flight
    drive_alu(1'b1, 5'd7, 32'h1234);
    tick();
    drive_alu(1'b0, 5'd0, '0);
    rs = 5'd7;
    rt = 5'd7;
    #1;
`ifdef WB_FWD_EN
    check("fwd_rs_hit", fwd_rs_hit, 1);
    check("fwd_rs_data", fwd_rs_data, 32'h1234);
    check("fwd_rt_hit", fwd_rt_hit, 1);
    check("fwd_rt_data", fwd_rt_data, 32'h1234);
`else
    check("fwd_rs_hit", fwd_rs_hit, 0);
    check("fwd_rs_data", fwd_rs_data, 0);
    check("fwd_rt_hit", fwd_rt_hit, 0);
    check("fwd_rt_data", fwd_rt_data, 0);
`endif
    rs = 5'd0;
    rt = 5'd0;
    tick();

    // Reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      drive_alu(1'b1, 5'd9, 32'hC0 + k);
      drive_md(1'b1, 5'(10 + k), 32'hF0 + k);
      tick();
    end
    check("pre_rst_occ", occupancy, 3);
    rst_n = 1'b0;
    drive_alu(1'b0, 5'd0, '0);
    drive_md(1'b0, 5'd0, '0);
    tick();
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_we", rf_we, 0);
    check("mid_rst_rd", rf_rd, 0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_we", rf_we, 0);
    check("post_rst_ready", md_ready, 1);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
